// File: rtl/display_pkg.sv
// Shared types and channel-selection helpers for the display scanner.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Helpers work on a 16-channel superset; callers zero-extend masks.
    localparam int MAX_CH = 16;

    typedef struct packed {
        logic [3:0] idx;
        logic       wrap;
    } next_ch_t;

    // Lowest set bit of the mask (0 when the mask is empty).
    function automatic logic [3:0] lowest_ch(input logic [MAX_CH-1:0] mask);
        logic [3:0] r;
        r = 4'd0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r = 4'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next enabled channel above cur; wraps to the lowest one and flags the wrap.
    function automatic next_ch_t next_ch(input logic [MAX_CH-1:0] mask,
                                         input logic [3:0]        cur);
        next_ch_t   r;
        logic [3:0] hi;
        logic       found;
        hi    = 4'd0;
        found = 1'b0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                hi    = 4'(i);
                found = 1'b1;
            end else begin
                hi    = hi;
            end
        end
        if (found) begin
            r.idx  = hi;
            r.wrap = 1'b0;
        end else begin
            r.idx  = lowest_ch(mask);
            r.wrap = 1'b1;
        end
        return r;
    endfunction

    // One-hot decode of a channel index, limited to num_ch channels.
    function automatic logic [MAX_CH-1:0] onehot(input logic [3:0] idx, input int num_ch);
        logic [MAX_CH-1:0] r;
        r = 16'd0;
        if (int'(idx) < num_ch) begin
            r[idx] = 1'b1;
        end else begin
            r = 16'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scan_mux_prescaler.sv
// Slot timer: counts 0..PRESCALE-1, flags the blank window and the last cycle.
module scan_prescaler #(
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 16,
    localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             in_blank,
    output logic             slot_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_r;

    // Slot counter: held at zero by clr, wraps only at the slot end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr || slot_end) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign count    = count_r;
    assign slot_end = (count_r == LAST);

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (count_r < CNT_W'(BLANK_CYC));
        end
    endgenerate

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner with channel masking, anti-ghost blanking
// and a per-frame snapshot of the channel data.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int                NUM_CH    = 5,
    parameter int                DATA_W    = 8,
    parameter int                PRESCALE  = 1000,
    parameter int                BLANK_CYC = 16,
    parameter logic [DATA_W-1:0] BLANK_VAL = {DATA_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        adress,
    output logic [DATA_W-1:0]        out,
    output logic                     frame_start
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    // A slot opens in BLANK unless there is no blank window at all.
    localparam scan_state_t SLOT_FIRST = (BLANK_CYC > 0) ? BLANK : SHOW;

    scan_state_t               state_r, state_nxt_s;
    logic [IDX_W-1:0]          ch_idx_r, ch_idx_nxt_s;
    logic [NUM_CH*DATA_W-1:0]  snap_r;
    logic                      snap_load_s;
    logic                      clr_s;
    logic                      fs_nxt_s;
    logic [CNT_W-1:0]          count_s;
    logic                      in_blank_s;
    logic                      slot_end_s;
    logic [MAX_CH-1:0]         mask16_s;
    next_ch_t                  nc_s;
    logic [DATA_W-1:0]         data_sel_s;
    logic [NUM_CH-1:0]         adress_nxt_s;
    logic [DATA_W-1:0]         out_nxt_s;
    logic [NUM_CH-1:0]         adress_r;
    logic [DATA_W-1:0]         out_r;
    logic                      frame_start_r;

    assign mask16_s = MAX_CH'(ch_mask);

    scan_prescaler #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .count    (count_s),
        .in_blank (in_blank_s),
        .slot_end (slot_end_s)
    );

    // Next-state logic: slot sequencing, channel selection and frame starts.
    always_comb begin
        state_nxt_s  = state_r;
        ch_idx_nxt_s = ch_idx_r;
        snap_load_s  = 1'b0;
        clr_s        = 1'b0;
        fs_nxt_s     = 1'b0;
        nc_s         = next_ch(mask16_s, 4'(ch_idx_r));
        if (!en) begin
            state_nxt_s  = IDLE;
            ch_idx_nxt_s = {IDX_W{1'b0}};
            clr_s        = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    clr_s = 1'b1;
                    if (ch_mask != {NUM_CH{1'b0}}) begin
                        state_nxt_s  = SLOT_FIRST;
                        ch_idx_nxt_s = IDX_W'(lowest_ch(mask16_s));
                        snap_load_s  = 1'b1;
                        fs_nxt_s     = 1'b1;
                    end else begin
                        state_nxt_s  = IDLE;
                    end
                end
                BLANK, SHOW: begin
                    if (slot_end_s) begin
                        // Slot boundary: the only place the mask is looked at.
                        if (ch_mask == {NUM_CH{1'b0}}) begin
                            state_nxt_s  = IDLE;
                            ch_idx_nxt_s = {IDX_W{1'b0}};
                            clr_s        = 1'b1;
                        end else begin
                            state_nxt_s  = SLOT_FIRST;
                            ch_idx_nxt_s = IDX_W'(nc_s.idx);
                            snap_load_s  = nc_s.wrap;
                            fs_nxt_s     = nc_s.wrap;
                        end
                    end else if ((state_r == BLANK) && in_blank_s && (count_s == BLANK_LAST)) begin
                        state_nxt_s = SHOW;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s  = IDLE;
                    ch_idx_nxt_s = {IDX_W{1'b0}};
                    clr_s        = 1'b1;
                end
            endcase
        end
    end

    // Output values for the upcoming cycle; a fresh snapshot is used the moment it loads.
    always_comb begin
        if (snap_load_s) begin
            data_sel_s = ch_data[ch_idx_nxt_s*DATA_W +: DATA_W];
        end else begin
            data_sel_s = snap_r[ch_idx_nxt_s*DATA_W +: DATA_W];
        end
        if (state_nxt_s == SHOW) begin
            adress_nxt_s = NUM_CH'(onehot(4'(ch_idx_nxt_s), NUM_CH));
            out_nxt_s    = data_sel_s;
        end else begin
            adress_nxt_s = {NUM_CH{1'b0}};
            out_nxt_s    = BLANK_VAL;
        end
    end

    // State, channel index and snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ch_idx_r <= {IDX_W{1'b0}};
            snap_r   <= {(NUM_CH*DATA_W){1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            ch_idx_r <= ch_idx_nxt_s;
            if (snap_load_s) begin
                snap_r <= ch_data;
            end else begin
                snap_r <= snap_r;
            end
        end
    end

    // Registered pin outputs, updated on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adress_r      <= {NUM_CH{1'b0}};
            out_r         <= BLANK_VAL;
            frame_start_r <= 1'b0;
        end else begin
            adress_r      <= adress_nxt_s;
            out_r         <= out_nxt_s;
            frame_start_r <= fs_nxt_s;
        end
    end

    assign adress      = adress_r;
    assign out         = out_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux: slot-level reference model plus
// hand-computed directed expectations.
module tb_display_scan_mux;

    localparam int NUM_CH    = 5;
    localparam int DATA_W    = 8;
    localparam int PRESCALE  = 8;
    localparam int BLANK_CYC = 2;
    localparam logic [7:0] BLANK_VAL = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  ch_mask = 5'b00000;
    logic [39:0] ch_data = 40'h0;
    logic [4:0]  adress;
    logic [7:0]  out;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    display_scan_mux #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC),
        .BLANK_VAL (BLANK_VAL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ch_mask     (ch_mask),
        .ch_data     (ch_data),
        .adress      (adress),
        .out         (out),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_active = 1'b0;
    int         m_cur = 0;
    int         m_pos = 0;
    int         m_nxt;
    logic [7:0] m_snap [NUM_CH];
    logic [4:0] exp_adr;
    logic [7:0] exp_out;
    logic       exp_fs;

    function automatic int first_above(input logic [4:0] m, input int after);
        for (int i = after + 1; i < NUM_CH; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic take_snapshot();
        for (int i = 0; i < NUM_CH; i++) m_snap[i] = ch_data[i*8 +: 8];
    endtask

    always @(posedge clk) begin
        exp_fs = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_cur    = 0;
            m_pos    = 0;
        end else if (!en) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (ch_mask != 5'b00000) begin
                m_active = 1'b1;
                m_cur    = first_above(ch_mask, -1);
                m_pos    = 0;
                take_snapshot();
                exp_fs   = 1'b1;
            end
        end else begin
            m_pos++;
            if (m_pos == PRESCALE) begin
                m_pos = 0;
                if (ch_mask == 5'b00000) begin
                    m_active = 1'b0;
                end else begin
                    m_nxt = first_above(ch_mask, m_cur);
                    if (m_nxt < 0) begin
                        m_nxt  = first_above(ch_mask, -1);
                        take_snapshot();
                        exp_fs = 1'b1;
                    end
                    m_cur = m_nxt;
                end
            end
        end
        if (m_active && (m_pos >= BLANK_CYC)) begin
            exp_adr = 5'(1 << m_cur);
            exp_out = m_snap[m_cur];
        end else begin
            exp_adr = 5'b00000;
            exp_out = BLANK_VAL;
        end
        #1;
        check("model_adress", 32'(adress), 32'(exp_adr));
        check("model_out", 32'(out), 32'(exp_out));
        check("model_frame_start", 32'(frame_start), 32'(exp_fs));
    end

    // ---------------- directed checks ----------------
    task automatic chk_now(input string name, input logic [4:0] a, input logic [7:0] o, input logic f);
        check({name, "_adress"}, 32'(adress), 32'(a));
        check({name, "_out"}, 32'(out), 32'(o));
        check({name, "_fs"}, 32'(frame_start), 32'(f));
    endtask

    task automatic chk_after(input int n, input string name, input logic [4:0] a,
                             input logic [7:0] o, input logic f);
        repeat (n) @(posedge clk);
        #2;
        chk_now(name, a, o, f);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        ch_mask = 5'b11111;
        ch_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        repeat (3) @(negedge clk);
        chk_now("in_reset", 5'b00000, 8'h00, 1'b0);

        // Release reset; k counts edges from the first frame start (k=0).
        @(negedge clk);
        rst_n = 1'b1;
        chk_after(1, "k0_start", 5'b00000, 8'h00, 1'b1);
        chk_after(1, "k1_blank", 5'b00000, 8'h00, 1'b0);
        chk_after(1, "k2_ch0", 5'b00001, 8'h11, 1'b0);
        chk_after(5, "k7_ch0_last", 5'b00001, 8'h11, 1'b0);
        chk_after(1, "k8_ch1_blank", 5'b00000, 8'h00, 1'b0);
        chk_after(2, "k10_ch1", 5'b00010, 8'h22, 1'b0);
        chk_after(8, "k18_ch2", 5'b00100, 8'h33, 1'b0);
        chk_after(8, "k26_ch3", 5'b01000, 8'h44, 1'b0);
        chk_after(8, "k34_ch4", 5'b10000, 8'h55, 1'b0);
        chk_after(6, "k40_frame", 5'b00000, 8'h00, 1'b1);

        // No tearing: ch2 changes during ch0's SHOW.
        chk_after(2, "k42_ch0", 5'b00001, 8'h11, 1'b0);
        @(negedge clk);
        ch_data[23:16] = 8'hAA;
        chk_after(16, "k58_ch2_old", 5'b00100, 8'h33, 1'b0);
        chk_after(40, "k98_ch2_new", 5'b00100, 8'hAA, 1'b0);

        // Masking to channels 2 and 4.
        @(negedge clk);
        ch_mask = 5'b10100;
        chk_after(8, "k106_mask_ch4", 5'b10000, 8'h55, 1'b0);
        chk_after(6, "k112_mask_frame", 5'b00000, 8'h00, 1'b1);
        chk_after(2, "k114_mask_ch2", 5'b00100, 8'hAA, 1'b0);
        chk_after(14, "k128_mask_frame", 5'b00000, 8'h00, 1'b1);

        // Disable during ch3's SHOW, then re-enable.
        @(negedge clk);
        ch_mask = 5'b11111;
        chk_after(10, "k138_ch3", 5'b01000, 8'h44, 1'b0);
        @(negedge clk);
        en = 1'b0;
        chk_after(1, "k139_disabled", 5'b00000, 8'h00, 1'b0);
        chk_after(3, "k142_disabled", 5'b00000, 8'h00, 1'b0);
        @(negedge clk);
        en = 1'b1;
        chk_after(1, "k143_restart", 5'b00000, 8'h00, 1'b1);
        chk_after(2, "k145_ch0", 5'b00001, 8'h11, 1'b0);

        // Zero mask: digit finishes its slot, then idle.
        @(negedge clk);
        ch_mask = 5'b00000;
        chk_after(5, "k150_ch0_last", 5'b00001, 8'h11, 1'b0);
        chk_after(1, "k151_idle", 5'b00000, 8'h00, 1'b0);
        chk_after(4, "k155_idle", 5'b00000, 8'h00, 1'b0);
        @(negedge clk);
        ch_mask = 5'b11111;
        chk_after(1, "k156_restart", 5'b00000, 8'h00, 1'b1);
        chk_after(2, "k158_ch0", 5'b00001, 8'h11, 1'b0);

        // Asynchronous reset mid-SHOW, checked before any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_now("async_reset", 5'b00000, 8'h00, 1'b0);

        // Single channel: every slot is a frame start.
        ch_mask = 5'b00100;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_after(1, "single_start", 5'b00000, 8'h00, 1'b1);
        chk_after(2, "single_ch2", 5'b00100, 8'hAA, 1'b0);
        chk_after(6, "single_frame2", 5'b00000, 8'h00, 1'b1);

        repeat (20) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
